// File: rtl/video_vtiming_seq_pkg.sv
// Shared constants and types for the video timing sequencer: default horizontal
// geometry, vertical PROM bit positions and the PROM fetch state encoding.
package video_timing_pkg;

  localparam int H_TOTAL_DEF       = 384;
  localparam int H_BLANK_START_DEF = 256;
  localparam int H_SYNC_START_DEF  = 288;
  localparam int H_SYNC_END_DEF    = 320;

  localparam int VT_VINT   = 0;
  localparam int VT_VSYNC  = 1;
  localparam int VT_VBLANK = 2;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_ADDR  = 2'd1,
    FS_WAIT  = 2'd2,
    FS_LATCH = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/video_vtiming_seq_if.sv
// Raster timing bundle: pixel enable, vertical PROM port and the timing outputs.
// master = sequencer side, slave = PROM / downstream consumer side.
interface video_vtiming_seq_if;

  logic       pix_ce;
  logic [7:0] prom_a;
  logic [3:0] prom_d;
  logic [8:0] hcount;
  logic [7:0] vcount;
  logic       line_start;
  logic       hblank;
  logic       hsync;
  logic       vblank;
  logic       vsync;
  logic       vint;

  modport master (
    input  pix_ce, prom_d,
    output prom_a, hcount, vcount, line_start, hblank, hsync, vblank, vsync, vint
  );

  modport slave (
    output pix_ce, prom_d,
    input  prom_a, hcount, vcount, line_start, hblank, hsync, vblank, vsync, vint
  );

endinterface

// File: rtl/video_vtiming_seq_hcount.sv
// Horizontal pixel counter with registered hblank/hsync/line_start decode.
// Decodes use the next count so every registered output lines up with hcount.
module video_hcount
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL       = H_TOTAL_DEF,
  parameter int H_BLANK_START = H_BLANK_START_DEF,
  parameter int H_SYNC_START  = H_SYNC_START_DEF,
  parameter int H_SYNC_END    = H_SYNC_END_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pix_ce,
  output logic [8:0] hcount,
  output logic       line_tick,
  output logic       line_start,
  output logic       hblank,
  output logic       hsync
);

  logic       wrap;
  logic [8:0] hcount_nxt;

  always_comb begin
    wrap       = pix_ce && (hcount == 9'(H_TOTAL - 1));
    hcount_nxt = hcount;
    if (pix_ce) begin
      hcount_nxt = wrap ? 9'd0 : hcount + 9'd1;
    end
  end

  // Combinational wrap strobe: lets the vertical side act on the same edge
  // that raises line_start, keeping flag latency at three clocks.
  assign line_tick = wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount     <= '0;
      line_start <= 1'b0;
      hblank     <= 1'b0;
      hsync      <= 1'b0;
    end else begin
      hcount     <= hcount_nxt;
      line_start <= wrap;
      hblank     <= (hcount_nxt >= 9'(H_BLANK_START));
      hsync      <= (hcount_nxt >= 9'(H_SYNC_START)) && (hcount_nxt < 9'(H_SYNC_END));
    end
  end

endmodule

// File: rtl/video_vtiming_seq.sv
// Video timing sequencer: horizontal counter, 8-bit line counter and a per-line
// fetch of the external vertical PROM decoded into vblank/vsync/vint.
module video_vtiming_seq
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL       = H_TOTAL_DEF,
  parameter int H_BLANK_START = H_BLANK_START_DEF,
  parameter int H_SYNC_START  = H_SYNC_START_DEF,
  parameter int H_SYNC_END    = H_SYNC_END_DEF
) (
  input logic          clk,
  input logic          reset_n,
  video_vtiming_seq_if.master vt
);

  logic [8:0]   hcount;
  logic         line_tick;
  logic         line_start;
  logic         hblank;
  logic         hsync;
  logic [7:0]   vcount;
  logic [7:0]   prom_a;
  logic         vblank;
  logic         vsync;
  logic         vint;
  logic         bit0_q;
  fetch_state_t state;

  video_hcount #(
    .H_TOTAL       (H_TOTAL),
    .H_BLANK_START (H_BLANK_START),
    .H_SYNC_START  (H_SYNC_START),
    .H_SYNC_END    (H_SYNC_END)
  ) u_hcount (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_ce     (vt.pix_ce),
    .hcount     (hcount),
    .line_tick  (line_tick),
    .line_start (line_start),
    .hblank     (hblank),
    .hsync      (hsync)
  );

  // Line counter wraps naturally; the PROM contents define the frame length.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vcount <= '0;
    end else if (line_tick) begin
      vcount <= vcount + 8'd1;
    end
  end

  // Fetch: ADDR drives the line address, WAIT covers the PROM register,
  // LATCH captures the word. Reset parks in ADDR so line 0 is fetched at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= FS_ADDR;
      prom_a <= '0;
      vblank <= 1'b0;
      vsync  <= 1'b0;
      bit0_q <= 1'b0;
      vint   <= 1'b0;
    end else begin
      vint <= 1'b0;
      case (state)
        FS_IDLE: begin
          if (line_tick) begin
            state <= FS_ADDR;
          end
        end
        FS_ADDR: begin
          prom_a <= vcount;
          state  <= FS_WAIT;
        end
        FS_WAIT: begin
          state <= FS_LATCH;
        end
        FS_LATCH: begin
          vblank <= vt.prom_d[VT_VBLANK];
          vsync  <= vt.prom_d[VT_VSYNC];
          bit0_q <= vt.prom_d[VT_VINT];
          vint   <= vt.prom_d[VT_VINT] & ~bit0_q;
          state  <= FS_IDLE;
        end
        default: begin
          state <= FS_IDLE;
        end
      endcase
    end
  end

  assign vt.hcount     = hcount;
  assign vt.vcount     = vcount;
  assign vt.line_start = line_start;
  assign vt.hblank     = hblank;
  assign vt.hsync      = hsync;
  assign vt.prom_a     = prom_a;
  assign vt.vblank     = vblank;
  assign vt.vsync      = vsync;
  assign vt.vint       = vint;

endmodule

// File: tb/tb_video_vtiming_seq.sv
// Bench for video_vtiming_seq: a short-line instance exercises full frames, a
// default-geometry instance exercises the real horizontal timing.
module tb_video_vtiming_seq;

  localparam int HTV = 8;
  localparam int HBV = 5;
  localparam int HSV = 6;
  localparam int HEV = 7;
  localparam int HTH = 384;
  localparam int HBH = 256;
  localparam int HSH = 288;
  localparam int HEH = 320;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic ce = 1'b0;

  always #5 clk = ~clk;

  video_vtiming_seq_if vif_v();
  video_vtiming_seq_if vif_h();

  video_vtiming_seq #(
    .H_TOTAL (HTV), .H_BLANK_START (HBV), .H_SYNC_START (HSV), .H_SYNC_END (HEV)
  ) dut_v (
    .clk (clk), .reset_n (reset_n), .vt (vif_v.master)
  );

  video_vtiming_seq dut_h (
    .clk (clk), .reset_n (reset_n), .vt (vif_h.master)
  );

  // Vertical PROM image: vblank 0xdc-0xfe, vsync 0xe7-0xf2, vint bit 0x5e-0x60,
  // bit 3 filled with junk that must be ignored.
  function automatic logic [3:0] rom_word(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {b[0], (v >= 220 && v <= 254), (v >= 231 && v <= 242), (v >= 94 && v <= 96)};
  endfunction

  always_ff @(posedge clk) vif_v.prom_d <= rom_word(int'(vif_v.prom_a));
  assign vif_h.prom_d = 4'h0;
  assign vif_v.pix_ce = ce;
  assign vif_h.pix_ce = ce;

  int   vectors;
  int   miscompares;
  int   pixcnt;
  int   t;
  int   vh[5];
  logic last_ce;

  // Reference: position derives from total pix_ce count; vertical flags show
  // the PROM word of the line that was current three clocks earlier.
  task automatic model_reset();
    pixcnt = 0;
    t = 0;
    last_ce = 1'b0;
    vh[0] = 0;
    for (int k = 1; k < 5; k++) vh[k] = -1;
  endtask

  task automatic tick(input logic c);
    ce = c;
    @(posedge clk);
    #1;
    t++;
    if (c) pixcnt++;
    last_ce = c;
    for (int k = 4; k > 0; k--) vh[k] = vh[k-1];
    vh[0] = (pixcnt / HTV) % 256;
  endtask

  function automatic logic [30:0] exp_v();
    int hc, pa;
    logic ls, hb, hs, vb, vs, vi;
    logic [3:0] w, wp;
    hc = pixcnt % HTV;
    pa = (vh[1] < 0) ? 0 : vh[1];
    ls = last_ce && (pixcnt > 0) && (hc == 0);
    hb = (hc >= HBV);
    hs = (hc >= HSV) && (hc < HEV);
    vb = 1'b0; vs = 1'b0; vi = 1'b0;
    if (vh[3] >= 0) begin
      w  = rom_word(vh[3]);
      wp = (vh[4] >= 0) ? rom_word(vh[4]) : 4'h0;
      vb = w[2];
      vs = w[1];
      vi = w[0] & ~wp[0];
    end
    return {9'(hc), 8'(vh[0]), 8'(pa), ls, hb, hs, vb, vs, vi};
  endfunction

  function automatic logic [11:0] exp_h();
    int hc;
    hc = pixcnt % HTH;
    return {9'(hc), last_ce && (pixcnt > 0) && (hc == 0), hc >= HBH, (hc >= HSH) && (hc < HEH)};
  endfunction

  function automatic logic [30:0] act_v();
    return {vif_v.hcount, vif_v.vcount, vif_v.prom_a, vif_v.line_start, vif_v.hblank,
            vif_v.hsync, vif_v.vblank, vif_v.vsync, vif_v.vint};
  endfunction

  function automatic logic [11:0] act_h();
    return {vif_h.hcount, vif_h.line_start, vif_h.hblank, vif_h.hsync};
  endfunction

  task automatic test_reset();
    ce = 1'b1;
    #3 reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (act_v() !== 31'h0 || act_h() !== 12'h0) begin
        miscompares++;
        $display("FAIL reset_state i=%0d got v=%h h=%h want 0", i, act_v(), act_h());
      end
      @(posedge clk);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_frame();
    logic [7:0] dv[4];
    logic       dls[4];
    logic       pvb, pvs;
    int         nvint;
    nvint = 0; pvb = 1'b0; pvs = 1'b0;
    for (int k = 0; k < 4; k++) begin dv[k] = '0; dls[k] = 1'b0; end
    for (int i = 0; i < 2100; i++) begin
      tick(1'b1);
      for (int k = 3; k > 0; k--) begin dv[k] = dv[k-1]; dls[k] = dls[k-1]; end
      dv[0] = vif_v.vcount;
      dls[0] = vif_v.line_start;
      vectors++;
      if (act_v() !== exp_v() || act_h() !== exp_h()) begin
        miscompares++;
        $display("FAIL frame t=%0d got v=%h h=%h want v=%h h=%h", t, act_v(), act_h(), exp_v(), exp_h());
      end
      if (vif_v.vblank && !pvb) begin
        vectors++;
        if (dv[3] !== 8'hdc || dls[3] !== 1'b1) begin
          miscompares++;
          $display("FAIL vblank_rise line=%h ls=%b want line=dc ls=1", dv[3], dls[3]);
        end
      end
      if (vif_v.vsync && !pvs) begin
        vectors++;
        if (dv[3] !== 8'he7 || dls[3] !== 1'b1) begin
          miscompares++;
          $display("FAIL vsync_rise line=%h ls=%b want line=e7 ls=1", dv[3], dls[3]);
        end
      end
      if (vif_v.vint) begin
        nvint++;
        vectors++;
        if (dv[3] !== 8'h5e || dls[3] !== 1'b1) begin
          miscompares++;
          $display("FAIL vint_pos line=%h ls=%b want line=5e ls=1", dv[3], dls[3]);
        end
      end
      pvb = vif_v.vblank;
      pvs = vif_v.vsync;
    end
    vectors++;
    if (nvint != 1) begin
      miscompares++;
      $display("FAIL vint_count got=%0d want=1", nvint);
    end
  endtask

  task automatic test_hline();
    int ls_t[$];
    int hb_n, hs_n;
    hb_n = 0; hs_n = 0;
    for (int i = 0; i < 800; i++) begin
      tick(1'b1);
      vectors++;
      if (act_h() !== exp_h()) begin
        miscompares++;
        $display("FAIL hline t=%0d got=%h want=%h", t, act_h(), exp_h());
      end
      if (vif_h.line_start) ls_t.push_back(i);
      if (ls_t.size() == 1) begin
        hb_n += int'(vif_h.hblank);
        hs_n += int'(vif_h.hsync);
      end
    end
    vectors++;
    if (ls_t.size() < 2) begin
      miscompares++;
      $display("FAIL hline_starts got=%0d want>=2", ls_t.size());
    end else if (ls_t[1] - ls_t[0] != HTH || hb_n != HTH - HBH || hs_n != HEH - HSH) begin
      miscompares++;
      $display("FAIL hline_shape period=%0d hblank=%0d hsync=%0d want 384/128/32",
               ls_t[1] - ls_t[0], hb_n, hs_n);
    end
  endtask

  task automatic test_pix_toggle();
    int ls_t[$];
    for (int i = 0; i < 200; i++) begin
      tick((i % 2) == 0);
      vectors++;
      if (act_v() !== exp_v() || act_h() !== exp_h()) begin
        miscompares++;
        $display("FAIL toggle t=%0d got v=%h h=%h want v=%h h=%h", t, act_v(), act_h(), exp_v(), exp_h());
      end
      if (vif_v.line_start) ls_t.push_back(i);
    end
    vectors++;
    if (ls_t.size() < 2 || ls_t[1] - ls_t[0] != 2 * HTV) begin
      miscompares++;
      $display("FAIL toggle_period got=%0d want=%0d", (ls_t.size() < 2) ? -1 : ls_t[1] - ls_t[0], 2 * HTV);
    end
  endtask

  task automatic test_random_ce();
    for (int i = 0; i < 600; i++) begin
      tick(logic'($urandom_range(0, 2) != 0));
      vectors++;
      if (act_v() !== exp_v() || act_h() !== exp_h()) begin
        miscompares++;
        $display("FAIL random_ce t=%0d got v=%h h=%h want v=%h h=%h", t, act_v(), act_h(), exp_v(), exp_h());
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      tick(1'b1);
      vectors++;
      if (act_v() !== exp_v()) begin
        miscompares++;
        $display("FAIL seek_e8 t=%0d got=%h want=%h", t, act_v(), exp_v());
      end
      if (vh[1] == 232 && vh[2] == 231) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL seek_e8 timeout got=none want=line e8");
      return;
    end
    vectors++;
    if (vif_v.vsync !== 1'b1 || vif_v.prom_a !== 8'he8) begin
      miscompares++;
      $display("FAIL pre_reset vsync=%b prom_a=%h want 1/e8", vif_v.vsync, vif_v.prom_a);
    end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (act_v() !== 31'h0 || act_h() !== 12'h0) begin
      miscompares++;
      $display("FAIL reset_async got v=%h h=%h want 0", act_v(), act_h());
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1);
      vectors++;
      if (act_v() !== exp_v()) begin
        miscompares++;
        $display("FAIL post_reset t=%0d got=%h want=%h", t, act_v(), exp_v());
      end
      if (i == 1 || i == 3) begin
        vectors++;
        if (vif_v.prom_a !== 8'h00 || (i == 3 && (vif_v.vblank !== 1'b0 || vif_v.vsync !== 1'b0))) begin
          miscompares++;
          $display("FAIL post_reset_clk%0d prom_a=%h vblank=%b vsync=%b want 00/0/0",
                   i, vif_v.prom_a, vif_v.vblank, vif_v.vsync);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int   wt;
    logic [7:0] prev_vc;
    wt = -1;
    prev_vc = vif_v.vcount;
    for (int i = 0; i < 2100; i++) begin
      tick(1'b1);
      vectors++;
      if (act_v() !== exp_v()) begin
        miscompares++;
        $display("FAIL wrap_run t=%0d got=%h want=%h", t, act_v(), exp_v());
      end
      if (vh[0] == 0 && vh[1] == 255) begin
        wt = t;
        vectors++;
        if (vif_v.vcount !== 8'h00 || prev_vc !== 8'hff) begin
          miscompares++;
          $display("FAIL vcount_wrap got=%h prev=%h want 00 prev ff", vif_v.vcount, prev_vc);
        end
      end
      if (wt >= 0 && t == wt + 1) begin
        vectors++;
        if (vif_v.prom_a !== 8'h00) begin
          miscompares++;
          $display("FAIL wrap_prom_a got=%h want=00", vif_v.prom_a);
        end
      end
      if (wt >= 0 && t == wt + 3) begin
        vectors++;
        if (vif_v.vblank !== 1'b0) begin
          miscompares++;
          $display("FAIL wrap_vblank got=%b want=0", vif_v.vblank);
        end
      end
      prev_vc = vif_v.vcount;
    end
    vectors++;
    if (wt < 0) begin
      miscompares++;
      $display("FAIL wrap_seen got=none want=ff->00");
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_reset();
    test_reset();
    test_frame();
    test_hline();
    test_pix_toggle();
    test_random_ce();
    test_reset_mid_fetch();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
